// File: rtl/wilson_spike_detector.sv
// wilson_spike_detector: threshold-crossing spike detector for the Wilson
// neuron's sign-magnitude Q15.16 membrane-potential stream. It enforces a
// refractory period, measures inter-spike intervals in integration steps
// and hands each ISI downstream over a valid/ready handshake.
//
// Build option: define WILSON_SPIKE_HYST_EN to re-arm at THRESHOLD - HYST
// instead of THRESHOLD (suppresses double spikes from ringing).
module wilson_spike_detector #(
    parameter logic [31:0] THRESHOLD     = 32'h00000000,
    parameter logic [31:0] HYST          = 32'h00001999,
    parameter int          REFRACT_STEPS = 16,
    parameter int          ISI_WIDTH     = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          v_in,
    input  logic                 v_valid,
    output logic                 spike,
    output logic [ISI_WIDTH-1:0] isi_data,
    output logic                 isi_valid,
    input  logic                 isi_ready,
    output logic                 overrun,
    output logic [15:0]          spike_count
);

`ifdef WILSON_SPIKE_HYST_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    // Sign-magnitude to 33-bit two's complement; negative zero maps to 0.
    function automatic logic signed [32:0] sm2tc(input logic [31:0] v);
        logic signed [32:0] m;
        m = {2'b00, v[30:0]};
        return v[31] ? -m : m;
    endfunction

    localparam logic signed [32:0] TH_TC    = sm2tc(THRESHOLD);
    localparam logic signed [32:0] REARM_TC = HYST_EN ? (TH_TC - $signed({1'b0, HYST}))
                                                      : TH_TC;
    localparam logic [7:0]         REFRACT_LD = 8'(REFRACT_STEPS);

    typedef enum logic [1:0] {
        S_INIT,
        S_ARMED,
        S_ABOVE,
        S_REFRACT
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_ref_cnt;
    logic [ISI_WIDTH-1:0]   r_isi_cnt;
    logic                   r_have_prev;
    logic                   r_spike;
    logic [ISI_WIDTH-1:0]   r_isi_data;
    logic                   r_isi_valid;
    logic                   r_overrun;
    logic [15:0]            r_spike_count;

    logic signed [32:0]     w_v_tc;
    logic                   w_at_th;
    logic                   w_below;
    logic                   w_fire;
    logic [ISI_WIDTH-1:0]   w_isi_next;

    assign w_v_tc     = sm2tc(v_in);
    assign w_at_th    = (w_v_tc >= TH_TC);
    assign w_below    = (w_v_tc < REARM_TC);
    assign w_fire     = v_valid && (r_state == S_ARMED) && w_at_th;
    // ISI reported on a spike sample counts that sample too (saturating).
    assign w_isi_next = (&r_isi_cnt) ? r_isi_cnt : r_isi_cnt + 1'b1;

    // Detector FSM, ISI counter, handshake register and spike statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_INIT;
            r_ref_cnt     <= '0;
            r_isi_cnt     <= '0;
            r_have_prev   <= 1'b0;
            r_spike       <= 1'b0;
            r_isi_data    <= '0;
            r_isi_valid   <= 1'b0;
            r_overrun     <= 1'b0;
            r_spike_count <= '0;
        end else begin
            r_spike <= 1'b0;

            // A pending word leaves on a completed transfer; a new word
            // below may reload it in the same cycle.
            if (r_isi_valid && isi_ready)
                r_isi_valid <= 1'b0;

            if (w_fire) begin
                r_spike       <= 1'b1;
                r_spike_count <= r_spike_count + 16'd1;
                r_have_prev   <= 1'b1;
                if (r_have_prev) begin
                    if (!r_isi_valid || isi_ready) begin
                        r_isi_data  <= w_isi_next;
                        r_isi_valid <= 1'b1;
                    end else begin
                        r_overrun   <= 1'b1;
                    end
                end
            end

            if (v_valid) begin
                if (w_fire)
                    r_isi_cnt <= '0;
                else if (r_state != S_INIT && !(&r_isi_cnt))
                    r_isi_cnt <= r_isi_cnt + 1'b1;

                case (r_state)
                    S_INIT: begin
                        if (w_below)
                            r_state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (w_at_th)
                            r_state <= S_ABOVE;
                    end
                    S_ABOVE: begin
                        if (w_below) begin
                            if (REFRACT_STEPS == 0) begin
                                r_state <= S_ARMED;
                            end else begin
                                r_state   <= S_REFRACT;
                                r_ref_cnt <= REFRACT_LD;
                            end
                        end
                    end
                    S_REFRACT: begin
                        r_ref_cnt <= r_ref_cnt - 8'd1;
                        if (r_ref_cnt <= 8'd1)
                            r_state <= S_ARMED;
                    end
                    default: r_state <= S_INIT;
                endcase
            end
        end
    end

    assign spike       = r_spike;
    assign isi_data    = r_isi_data;
    assign isi_valid   = r_isi_valid;
    assign overrun     = r_overrun;
    assign spike_count = r_spike_count;

endmodule
